// File: rtl/operation_sequencer.sv
// Command sequencer for the add/subtract processor: buffers commands in a FIFO,
// issues them one at a time, waits the fixed processor latency, returns the result.
module operation_sequencer #(
  parameter int WORDSIZE     = 64,
  parameter int FIFO_DEPTH   = 4,
  parameter int PROC_LATENCY = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [WORDSIZE-1:0]           cmd_num1,
  input  logic [WORDSIZE-1:0]           cmd_num2,
  input  logic                          cmd_operation,
  output logic [WORDSIZE-1:0]           proc_num1,
  output logic [WORDSIZE-1:0]           proc_num2,
  output logic                          proc_operation,
  output logic                          proc_start,
  input  logic [WORDSIZE-1:0]           proc_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WORDSIZE-1:0]           rsp_result,
  output logic                          rsp_operation,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(PROC_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, next_state;

  logic [WORDSIZE-1:0] num1_mem [FIFO_DEPTH];
  logic [WORDSIZE-1:0] num2_mem [FIFO_DEPTH];
  logic                op_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [LAT_W-1:0]    lat_cnt;
  logic                push, pop;

  // Ready depends only on the registered count, so a full FIFO refuses a push even when popping.
  assign cmd_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      num1_mem[wr_ptr] <= cmd_num1;
      num2_mem[wr_ptr] <= cmd_num2;
      op_mem[wr_ptr]   <= cmd_operation;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    proc_start = 1'b0;
    rsp_valid  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:  if (fifo_count != '0) next_state = ISSUE;
      ISSUE: begin
        proc_start = 1'b1;
        next_state = WAIT;
      end
      WAIT:  if (lat_cnt == '0) next_state = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand registers hold their last command between issues; results are captured verbatim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_num1      <= '0;
      proc_num2      <= '0;
      proc_operation <= 1'b0;
      rsp_result     <= '0;
      rsp_operation  <= 1'b0;
      lat_cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          proc_num1      <= num1_mem[rd_ptr];
          proc_num2      <= num2_mem[rd_ptr];
          proc_operation <= op_mem[rd_ptr];
        end
        ISSUE: lat_cnt <= LAT_W'(PROC_LATENCY - 1);
        WAIT: begin
          if (lat_cnt == '0) begin
            rsp_result    <= proc_result;
            rsp_operation <= proc_operation;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operation_sequencer.sv
// Directed self-checking bench for operation_sequencer with a fixed-latency
// add/subtract processor model attached to the proc_* side.
module tb_operation_sequencer;

  localparam int WORDSIZE     = 64;
  localparam int FIFO_DEPTH   = 4;
  localparam int PROC_LATENCY = 7;
  localparam int CW           = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WORDSIZE-1:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic                clk;
  logic                rst_n;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [WORDSIZE-1:0] cmd_num1;
  logic [WORDSIZE-1:0] cmd_num2;
  logic                cmd_operation;
  logic [WORDSIZE-1:0] proc_num1;
  logic [WORDSIZE-1:0] proc_num2;
  logic                proc_operation;
  logic                proc_start;
  logic [WORDSIZE-1:0] proc_result;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WORDSIZE-1:0] rsp_result;
  logic                rsp_operation;
  logic                busy;
  logic [CW-1:0]       fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int start_count = 0;
  logic [WORDSIZE:0] rsp_q[$];
  logic [WORDSIZE:0] exp_q[$];

  operation_sequencer #(
    .WORDSIZE(WORDSIZE), .FIFO_DEPTH(FIFO_DEPTH), .PROC_LATENCY(PROC_LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_num1(cmd_num1), .cmd_num2(cmd_num2), .cmd_operation(cmd_operation),
    .proc_num1(proc_num1), .proc_num2(proc_num2), .proc_operation(proc_operation),
    .proc_start(proc_start), .proc_result(proc_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_operation(rsp_operation),
    .busy(busy), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Processor model: result is only valid exactly PROC_LATENCY cycles after the start pulse.
  logic [WORDSIZE-1:0] model_r;
  int                  model_d;
  logic                model_active;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_active <= 1'b0;
      model_d      <= 0;
      model_r      <= '0;
    end else if (proc_start) begin
      model_active <= 1'b1;
      model_d      <= PROC_LATENCY - 1;
      model_r      <= proc_operation ? proc_num1 - proc_num2 : proc_num1 + proc_num2;
    end else if (model_active) begin
      if (model_d == 0) model_active <= 1'b0;
      else              model_d <= model_d - 1;
    end
  end
  assign proc_result = (model_active && model_d == 0) ? model_r : JUNK;

  always @(posedge clk) begin
    if (rst_n) begin
      if (proc_start) start_count++;
      if (rsp_valid && rsp_ready) rsp_q.push_back({rsp_operation, rsp_result});
    end
  end

  task automatic checkOutput(input string tag, input logic [WORDSIZE:0] got, input logic [WORDSIZE:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called and returns on a falling edge; the push lands on the rising edge in between.
  task automatic applyStimulus(input logic [WORDSIZE-1:0] n1, input logic [WORDSIZE-1:0] n2, input logic op);
    int k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      checkOutput("push_timeout", 0, 1);
      return;
    end
    cmd_valid     = 1'b1;
    cmd_num1      = n1;
    cmd_num2      = n2;
    cmd_operation = op;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic takeResponse(input string tag, input logic [WORDSIZE-1:0] exp_r, input logic exp_op);
    int k = 0;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!rsp_valid) begin
      checkOutput({tag, "_timeout"}, 0, 1);
    end else begin
      checkOutput({tag, "_result"}, {1'b0, rsp_result}, {1'b0, exp_r});
      checkOutput({tag, "_op"}, {64'd0, rsp_operation}, {64'd0, exp_op});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic collectAndCheck(input string tag, input int base);
    int k = 0;
    while ((rsp_q.size() - base) < exp_q.size() && k < 300) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, "_count"}, 65'(rsp_q.size() - base), 65'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < rsp_q.size())
        checkOutput($sformatf("%s_rsp%0d", tag, i), rsp_q[base + i], exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int starts;
    int cyc;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_num1 = '0; cmd_num2 = '0;
    cmd_operation = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkOutput("reset_cmd_ready", {64'd0, cmd_ready}, 65'd1);
    checkOutput("reset_busy", {64'd0, busy}, 65'd0);
    checkOutput("reset_rsp_valid", {64'd0, rsp_valid}, 65'd0);
    checkOutput("reset_proc_start", {64'd0, proc_start}, 65'd0);
    checkOutput("reset_fifo_count", 65'(fifo_count), 65'd0);
    checkOutput("reset_rsp_result", {1'b0, rsp_result}, 65'd0);

    $display("[TB] single add command");
    starts = start_count;
    applyStimulus(64'd5, 64'd3, 1'b0);
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("add_latency", 65'(cyc), 65'(PROC_LATENCY + 3));
    takeResponse("add", 64'd8, 1'b0);
    checkOutput("add_start_pulses", 65'(start_count - starts), 65'd1);

    $display("[TB] subtract command");
    applyStimulus(64'd3, 64'd5, 1'b1);
    takeResponse("sub", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);

    $display("[TB] fill and backpressure");
    base = rsp_q.size();
    applyStimulus(64'd10, 64'd1, 1'b0);
    applyStimulus(64'd20, 64'd5, 1'b1);
    applyStimulus(64'd7, 64'd7, 1'b0);
    applyStimulus(64'd100, 64'd1, 1'b1);
    applyStimulus(64'd1, 64'd2, 1'b1);
    checkOutput("full_count", 65'(fifo_count), 65'(FIFO_DEPTH));
    checkOutput("full_cmd_ready", {64'd0, cmd_ready}, 65'd0);
    repeat (5) @(negedge clk);
    checkOutput("full_hold_count", 65'(fifo_count), 65'(FIFO_DEPTH));
    rsp_ready = 1'b1;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    checkOutput("refill_count", 65'(fifo_count), 65'(FIFO_DEPTH));
    exp_q = '{{1'b0, 64'd11}, {1'b1, 64'd15}, {1'b0, 64'd14},
              {1'b1, 64'd99}, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF}, {1'b0, 64'd0}};
    collectAndCheck("fill", base);
    rsp_ready = 1'b0;

    $display("[TB] simultaneous push and pop, pointer wrap");
    base = rsp_q.size();
    applyStimulus(64'd1, 64'd1, 1'b0);
    applyStimulus(64'd50, 64'd8, 1'b1);
    applyStimulus(64'd9, 64'd9, 1'b1);
    rsp_ready = 1'b1;
    cyc = 0;
    while (busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("pushpop_before", 65'(fifo_count), 65'd2);
    applyStimulus(64'd123, 64'd456, 1'b0);
    checkOutput("pushpop_after", 65'(fifo_count), 65'd2);
    exp_q = '{{1'b0, 64'd2}, {1'b1, 64'd42}, {1'b1, 64'd0}, {1'b0, 64'd579}};
    collectAndCheck("wrap", base);
    rsp_ready = 1'b0;

    $display("[TB] reset during WAIT");
    applyStimulus(64'd2, 64'd2, 1'b0);
    applyStimulus(64'd11, 64'd1, 1'b0);
    applyStimulus(64'd12, 64'd1, 1'b0);
    applyStimulus(64'd13, 64'd1, 1'b0);
    checkOutput("prereset_count", 65'(fifo_count), 65'd3);
    checkOutput("prereset_busy", {64'd0, busy}, 65'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_count", 65'(fifo_count), 65'd0);
    checkOutput("midreset_busy", {64'd0, busy}, 65'd0);
    checkOutput("midreset_rsp_valid", {64'd0, rsp_valid}, 65'd0);
    checkOutput("midreset_rsp_result", {1'b0, rsp_result}, 65'd0);
    checkOutput("midreset_proc_num1", {1'b0, proc_num1}, 65'd0);
    checkOutput("midreset_proc_op", {64'd0, proc_operation}, 65'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    base = rsp_q.size();
    starts = start_count;
    repeat (20) @(negedge clk);
    checkOutput("postreset_no_rsp", 65'(rsp_q.size() - base), 65'd0);
    checkOutput("postreset_no_start", 65'(start_count - starts), 65'd0);
    rsp_ready = 1'b0;
    applyStimulus(64'd40, 64'd2, 1'b1);
    takeResponse("postreset", 64'd38, 1'b1);

    $display("[TB] stall in DONE");
    applyStimulus(64'd100, 64'd23, 1'b0);
    applyStimulus(64'd100, 64'd23, 1'b1);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    starts = start_count;
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("stall_valid%0d", i), {64'd0, rsp_valid}, 65'd1);
      checkOutput($sformatf("stall_result%0d", i), {1'b0, rsp_result}, 65'd123);
      checkOutput($sformatf("stall_op%0d", i), {64'd0, rsp_operation}, 65'd0);
      @(negedge clk);
    end
    checkOutput("stall_no_start", 65'(start_count - starts), 65'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("release_idle_start", {64'd0, proc_start}, 65'd0);
    checkOutput("release_idle_busy", {64'd0, busy}, 65'd0);
    @(negedge clk);
    checkOutput("release_issue_start", {64'd0, proc_start}, 65'd1);
    takeResponse("stall_next", 64'd77, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
